random_seq_player: RTL and testbench

- Consumes the 20-bit random value produced by the level-select random number logic and unpacks it into a sequence of 3-bit target indices (0..7).
- Presents the indices one at a time to the display, with show time scaled by game level.
- Then checks the player's keypad entries against the sequence and reports pass or fail.
- Sits between the random number source, the keypad decoder and the display driver.

---
 rtl/random_seq_player.sv | 203 ++++++++++++++++++++
 tb/tb_random_seq_player.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/random_seq_player.sv
// rtl/random_seq_player.sv - unpacks a random value into an index sequence, shows it, then checks keypad entries
//
// Purpose:
//   An accepted start captures random_num and level. The block then shows
//   SEQ_LEN 3-bit indices one at a time, each followed by a blank gap. After
//   that it compares the player's key entries with the sequence and ends in
//   PASS or FAIL.
//
// Ports:
//   clk        in   system clock, rising edge
//   keypad_0   in   synchronous active-high reset
//   start      in   single-cycle round request (honoured in IDLE/PASS/FAIL)
//   random_num in   20-bit random value, sampled on an accepted start
//   level      in   2-bit difficulty, sampled on an accepted start
//   key_valid  in   single-cycle key strobe
//   key_idx    in   3-bit key position
//   show_valid out  an index is being displayed
//   show_idx   out  displayed index, 0 when show_valid is low
//   busy       out  round in progress (SHOW/GAP/INPUT)
//   progress   out  correct keys entered this round
//   done       out  one-cycle pulse on entering PASS or FAIL
//   pass       out  held high in PASS
//   fail       out  held high in FAIL

module random_seq_player #(
    parameter int SEQ_LEN    = 6,
    parameter int SHOW_TICKS = 8,
    parameter int GAP_TICKS  = 2
) (
    input  logic        clk,
    input  logic        keypad_0,
    input  logic        start,
    input  logic [19:0] random_num,
    input  logic [1:0]  level,
    input  logic        key_valid,
    input  logic [2:0]  key_idx,
    output logic        show_valid,
    output logic [2:0]  show_idx,
    output logic        busy,
    output logic [2:0]  progress,
    output logic        done,
    output logic        pass,
    output logic        fail
);

    localparam int TMAX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] SHOW_T    = TW'(SHOW_TICKS);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
    localparam logic [TW-1:0] T_ONE     = TW'(1);
    localparam logic [2:0]    LAST_STEP = 3'(SEQ_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW,
        S_GAP,
        S_INPUT,
        S_PASS,
        S_FAIL
    } state_t;

    state_t state, state_nx;

    logic [17:0]   seq_q;
    logic [1:0]    level_q;
    logic [2:0]    step_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    progress_q;
    logic          done_q;

    logic [2:0]    idx_tab [8];
    logic [2:0]    cur_idx;
    logic [TW-1:0] show_last;
    logic          show_end;
    logic          gap_end;
    logic          start_ok;
    logic          key_hit;

    // Index i lives in seq_q[3i+2:3i]; table slots past SEQ_LEN are never
    // selected because step never exceeds SEQ_LEN-1 while it is used.
    for (genvar i = 0; i < 8; i++) begin : g_idx
        if (i < SEQ_LEN) begin : g_used
            assign idx_tab[i] = seq_q[3*i +: 3];
        end else begin : g_unused
            assign idx_tab[i] = 3'd0;
        end
    end

    assign cur_idx   = idx_tab[step_q];
    // Higher levels halve the show time per step.
    assign show_last = (SHOW_T >> level_q) - T_ONE;
    assign show_end  = (timer_q == show_last);
    assign gap_end   = (timer_q == GAP_LAST);

    always_ff @(posedge clk) begin
        if (keypad_0) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        start_ok   = 1'b0;
        key_hit    = 1'b0;
        show_valid = 1'b0;
        show_idx   = 3'd0;
        busy       = 1'b0;
        pass       = 1'b0;
        fail       = 1'b0;

        case (state)
            S_IDLE, S_PASS, S_FAIL: begin
                pass = (state == S_PASS);
                fail = (state == S_FAIL);
                if (start) begin
                    start_ok = 1'b1;
                    state_nx = S_SHOW;
                end
            end
            S_SHOW: begin
                show_valid = 1'b1;
                show_idx   = cur_idx;
                busy       = 1'b1;
                if (show_end) begin
                    state_nx = S_GAP;
                end
            end
            S_GAP: begin
                busy = 1'b1;
                if (gap_end) begin
                    state_nx = (step_q == LAST_STEP) ? S_INPUT : S_SHOW;
                end
            end
            S_INPUT: begin
                busy = 1'b1;
                if (key_valid) begin
                    if (key_idx == cur_idx) begin
                        key_hit = 1'b1;
                        if (step_q == LAST_STEP) begin
                            state_nx = S_PASS;
                        end
                    end else begin
                        state_nx = S_FAIL;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (keypad_0) begin
            seq_q      <= '0;
            level_q    <= '0;
            step_q     <= '0;
            timer_q    <= '0;
            progress_q <= '0;
            done_q     <= 1'b0;
        end else begin
            // done marks only the first cycle of a terminal state.
            done_q <= ((state_nx == S_PASS) || (state_nx == S_FAIL)) && (state_nx != state);

            if (start_ok) begin
                seq_q      <= random_num[17:0];
                level_q    <= level;
                step_q     <= '0;
                timer_q    <= '0;
                progress_q <= '0;
            end else begin
                case (state)
                    S_SHOW: begin
                        timer_q <= show_end ? '0 : timer_q + T_ONE;
                    end
                    S_GAP: begin
                        if (gap_end) begin
                            timer_q <= '0;
                            step_q  <= (step_q == LAST_STEP) ? 3'd0 : step_q + 3'd1;
                        end else begin
                            timer_q <= timer_q + T_ONE;
                        end
                    end
                    S_INPUT: begin
                        if (key_hit) begin
                            progress_q <= progress_q + 3'd1;
                            step_q     <= step_q + 3'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign progress = progress_q;
    assign done     = done_q;

endmodule

// File: tb/tb_random_seq_player.sv
// tb/tb_random_seq_player.sv - table-driven scoreboard bench for random_seq_player

module tb_random_seq_player;

    localparam int SEQ_LEN    = 6;
    localparam int SHOW_TICKS = 8;
    localparam int GAP_TICKS  = 2;

    logic        clk = 1'b0;
    logic        keypad_0;
    logic        start;
    logic [19:0] random_num;
    logic [1:0]  level;
    logic        key_valid;
    logic [2:0]  key_idx;
    logic        show_valid;
    logic [2:0]  show_idx;
    logic        busy;
    logic [2:0]  progress;
    logic        done;
    logic        pass;
    logic        fail;

    random_seq_player #(
        .SEQ_LEN   (SEQ_LEN),
        .SHOW_TICKS(SHOW_TICKS),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .clk       (clk),
        .keypad_0  (keypad_0),
        .start     (start),
        .random_num(random_num),
        .level     (level),
        .key_valid (key_valid),
        .key_idx   (key_idx),
        .show_valid(show_valid),
        .show_idx  (show_idx),
        .busy      (busy),
        .progress  (progress),
        .done      (done),
        .pass      (pass),
        .fail      (fail)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sv;
        logic [2:0] idx;
        logic       busy;
        logic [2:0] prog;
        logic       done;
        logic       pass;
        logic       fail;
    } obs_t;

    typedef struct {
        string       name;
        logic [19:0] rnd;
        logic [1:0]  lvl;
        logic [17:0] keys;
        int          nkeys;
        bit          disturb;
        int          abort_at;
        logic        exp_pass;
        logic [2:0]  exp_prog;
    } round_t;

    obs_t   exp_q[$];
    round_t tab[9];
    int     total = 0;
    int     bad   = 0;

    function automatic obs_t mk(input logic sv_i, input logic [2:0] idx_i, input logic busy_i,
                                input logic [2:0] prog_i, input logic done_i,
                                input logic pass_i, input logic fail_i);
        obs_t o;
        o.sv   = sv_i;
        o.idx  = idx_i;
        o.busy = busy_i;
        o.prog = prog_i;
        o.done = done_i;
        o.pass = pass_i;
        o.fail = fail_i;
        return o;
    endfunction

    task automatic check_cycle(input string name);
        obs_t a;
        obs_t e;
        a = {show_valid, show_idx, busy, progress, done, pass, fail};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, got %h", name, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                bad++;
                $display("FAIL %s t=%0t: got sv=%0b idx=%0d busy=%0b prog=%0d done=%0b pass=%0b fail=%0b, want sv=%0b idx=%0d busy=%0b prog=%0d done=%0b pass=%0b fail=%0b",
                         name, $time, a.sv, a.idx, a.busy, a.prog, a.done, a.pass, a.fail,
                         e.sv, e.idx, e.busy, e.prog, e.done, e.pass, e.fail);
            end
        end
    endtask

    task automatic run_round(input round_t r);
        int         s;
        int         n;
        int         prog;
        bit         ended;
        logic [2:0] ix;
        logic [2:0] k;

        s = SHOW_TICKS >> r.lvl;
        start      = 1'b1;
        random_num = r.rnd;
        level      = r.lvl;
        for (int i = 0; i < SEQ_LEN; i++) begin
            ix = r.rnd[3*i +: 3];
            repeat (s) exp_q.push_back(mk(1'b1, ix, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0));
            repeat (GAP_TICKS) exp_q.push_back(mk(1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0));
        end
        // first INPUT cycle plus a few idle cycles: no timeout expected
        repeat (4) exp_q.push_back(mk(1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0));

        n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            start     = 1'b0;
            key_valid = 1'b0;
            check_cycle(r.name);
            n++;
            if (r.abort_at == n) begin
                keypad_0 = 1'b1;
                exp_q.delete();
                exp_q.push_back(mk(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
                @(negedge clk);
                check_cycle({r.name, "_rst"});
                keypad_0 = 1'b0;
                return;
            end
            if (r.disturb && n == 3) begin
                random_num = 20'h00000;
                key_valid  = 1'b1;
                key_idx    = 3'd0;
                start      = 1'b1;
            end
        end

        prog  = 0;
        ended = 1'b0;
        for (int j = 0; j < r.nkeys && !ended; j++) begin
            k         = r.keys[3*j +: 3];
            ix        = r.rnd[3*j +: 3];
            key_valid = 1'b1;
            key_idx   = k;
            if (r.disturb && j == 0) start = 1'b1;
            if (k == ix) begin
                prog++;
                if (prog == SEQ_LEN) begin
                    exp_q.push_back(mk(1'b0, 3'd0, 1'b0, 3'(prog), 1'b1, 1'b1, 1'b0));
                    exp_q.push_back(mk(1'b0, 3'd0, 1'b0, 3'(prog), 1'b0, 1'b1, 1'b0));
                    ended = 1'b1;
                end else begin
                    exp_q.push_back(mk(1'b0, 3'd0, 1'b1, 3'(prog), 1'b0, 1'b0, 1'b0));
                end
            end else begin
                exp_q.push_back(mk(1'b0, 3'd0, 1'b0, 3'(prog), 1'b1, 1'b0, 1'b1));
                exp_q.push_back(mk(1'b0, 3'd0, 1'b0, 3'(prog), 1'b0, 1'b0, 1'b1));
                ended = 1'b1;
            end
            @(negedge clk);
            key_valid = 1'b0;
            start     = 1'b0;
            check_cycle({r.name, "_key"});
        end
        while (exp_q.size() > 0) begin
            @(negedge clk);
            check_cycle({r.name, "_end"});
        end

        total++;
        if (pass !== r.exp_pass || progress !== r.exp_prog) begin
            bad++;
            $display("FAIL %s_result: got pass=%0b progress=%0d, want pass=%0b progress=%0d",
                     r.name, pass, progress, r.exp_pass, r.exp_prog);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = '{"lvl0_pass",   20'h2C688, 2'd0, 18'h2C688, 6, 1'b0, 0,  1'b1, 3'd6};
        tab[1] = '{"lvl3_pass",   20'h2C688, 2'd3, 18'h2C688, 6, 1'b0, 0,  1'b1, 3'd6};
        tab[2] = '{"lvl0_fail",   20'h2C688, 2'd0, 18'h001C8, 3, 1'b0, 0,  1'b0, 3'd2};
        tab[3] = '{"disturb",     20'h2C688, 2'd1, 18'h2C688, 6, 1'b1, 0,  1'b1, 3'd6};
        tab[4] = '{"all_sevens",  20'hFFFFF, 2'd2, 18'h3FFFF, 6, 1'b0, 0,  1'b1, 3'd6};
        tab[5] = '{"high_bits",   20'h3FFFF, 2'd3, 18'h3FFFF, 6, 1'b0, 0,  1'b1, 3'd6};
        tab[6] = '{"reset_mid",   20'h2C688, 2'd0, 18'h2C688, 0, 1'b0, 21, 1'b0, 3'd0};
        tab[7] = '{"replay",      20'h2C688, 2'd0, 18'h2C688, 6, 1'b0, 0,  1'b1, 3'd6};
        tab[8] = '{"first_wrong", 20'h12345, 2'd2, 18'h00003, 1, 1'b0, 0,  1'b0, 3'd0};

        keypad_0   = 1'b1;
        start      = 1'b0;
        random_num = 20'h0;
        level      = 2'd0;
        key_valid  = 1'b0;
        key_idx    = 3'd0;

        repeat (2) @(negedge clk);
        exp_q.push_back(mk(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
        check_cycle("reset_state");
        keypad_0 = 1'b0;

        // key strobe in IDLE must be ignored
        key_valid = 1'b1;
        key_idx   = 3'd0;
        exp_q.push_back(mk(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        key_valid = 1'b0;
        check_cycle("idle_key");

        for (int i = 0; i < 9; i++) begin
            run_round(tab[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
